// File: rtl/scan_config_loader.sv
// scan_config_loader
// Writer end of a per-tile serial configuration chain. Host words arrive over a
// valid/ready handshake and are shifted LSB first into the chain. The chain is
// then recirculated once so a CRC-8 of the bits coming out can be compared with
// a CRC-8 of the bits that went in, leaving the configuration intact.
module scan_config_loader #(
    parameter int CHAIN_LENGTH = 8,
    parameter int WORD_WIDTH   = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  chain_scan_in,
    output logic                  chain_scan_en,
    input  logic                  chain_scan_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        VERIFY,
        FINISH
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CHAIN_CNT = CNT_WIDTH'(CHAIN_LENGTH);
    // A single word can never contribute more bits than the whole chain holds.
    localparam logic [CNT_WIDTH-1:0] WORD_CNT =
        (WORD_WIDTH < CHAIN_LENGTH) ? CNT_WIDTH'(WORD_WIDTH) : CHAIN_CNT;

    // Bit-serial CRC-8, polynomial x^8+x^2+x+1.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    state_t                state;
    logic [WORD_WIDTH-1:0] word_sr;
    logic [CNT_WIDTH-1:0]  bits_this_word;
    logic [CNT_WIDTH-1:0]  bits_loaded;
    logic [CNT_WIDTH-1:0]  shift_cnt;
    logic [CNT_WIDTH-1:0]  verify_cnt;
    logic [7:0]            crc_in;
    logic [7:0]            crc_out;
    logic                  scan_bit;

    logic [CNT_WIDTH-1:0]  remaining;
    logic [CNT_WIDTH-1:0]  word_bits;
    logic [CNT_WIDTH-1:0]  bits_loaded_inc;
    logic [CNT_WIDTH-1:0]  shift_cnt_inc;
    logic [CNT_WIDTH-1:0]  verify_cnt_inc;
    logic [7:0]            crc_in_nxt;
    logic [7:0]            crc_out_nxt;
    logic                  next_bit;
    logic                  accept;

    assign accept          = data_valid && data_ready;
    assign remaining       = CHAIN_CNT - bits_loaded;
    assign word_bits       = (remaining < WORD_CNT) ? remaining : WORD_CNT;
    assign bits_loaded_inc = bits_loaded + CNT_WIDTH'(1);
    assign shift_cnt_inc   = shift_cnt + CNT_WIDTH'(1);
    assign verify_cnt_inc  = verify_cnt + CNT_WIDTH'(1);
    assign crc_in_nxt      = crc8_step(crc_in, word_sr[0]);
    assign crc_out_nxt     = crc8_step(crc_out, chain_scan_out);

    // The bit that will sit at word_sr[0] after the next shift.
    if (WORD_WIDTH > 1) begin : g_next_bit
        assign next_bit = word_sr[1];
    end else begin : g_next_bit_single
        assign next_bit = 1'b0;
    end

    // During VERIFY the chain output is fed straight back so the contents rotate
    // back into place; otherwise the registered shift bit (0 outside SHIFT).
    assign chain_scan_in = (state == VERIFY) ? chain_scan_out : scan_bit;

    // Word shift register: holds datapath only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == LOAD && accept) begin
            word_sr <= data_in;
        end else if (state == SHIFT) begin
            word_sr <= word_sr >> 1;
        end
    end

    // Control FSM; every output is registered against the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bits_this_word <= '0;
            bits_loaded    <= '0;
            shift_cnt      <= '0;
            verify_cnt     <= '0;
            crc_in         <= '0;
            crc_out        <= '0;
            scan_bit       <= 1'b0;
            data_ready     <= 1'b0;
            chain_scan_en  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= LOAD;
                        busy           <= 1'b1;
                        data_ready     <= 1'b1;
                        error          <= 1'b0;
                        crc_in         <= '0;
                        crc_out        <= '0;
                        bits_loaded    <= '0;
                        bits_this_word <= '0;
                        shift_cnt      <= '0;
                        verify_cnt     <= '0;
                    end
                end

                LOAD: begin
                    if (accept) begin
                        state          <= SHIFT;
                        data_ready     <= 1'b0;
                        chain_scan_en  <= 1'b1;
                        scan_bit       <= data_in[0];
                        bits_this_word <= word_bits;
                        shift_cnt      <= '0;
                    end
                end

                SHIFT: begin
                    crc_in      <= crc_in_nxt;
                    bits_loaded <= bits_loaded_inc;
                    shift_cnt   <= shift_cnt_inc;
                    if (shift_cnt_inc == bits_this_word) begin
                        // Remaining upper bits of this word are simply dropped.
                        scan_bit <= 1'b0;
                        if (bits_loaded_inc == CHAIN_CNT) begin
                            state      <= VERIFY;
                            verify_cnt <= '0;
                        end else begin
                            state         <= LOAD;
                            chain_scan_en <= 1'b0;
                            data_ready    <= 1'b1;
                        end
                    end else begin
                        scan_bit <= next_bit;
                    end
                end

                VERIFY: begin
                    crc_out    <= crc_out_nxt;
                    verify_cnt <= verify_cnt_inc;
                    if (verify_cnt_inc == CHAIN_CNT) begin
                        state         <= FINISH;
                        chain_scan_en <= 1'b0;
                        done          <= 1'b1;
                        // Compare with the final CRC so error is valid alongside done.
                        error         <= (crc_out_nxt != crc_in);
                    end
                end

                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state         <= IDLE;
                    scan_bit      <= 1'b0;
                    data_ready    <= 1'b0;
                    chain_scan_en <= 1'b0;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_config_loader.sv
// Bench for scan_config_loader: one instance with an 8-bit chain, one with a
// 12-bit chain, each attached to a shift-register model of the chain.
module tb_scan_config_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, start_b;
    logic       data_valid;
    logic [7:0] data_in;

    logic ready_a, sin_a, en_a, busy_a, done_a, err_a, sout_a;
    logic ready_b, sin_b, en_b, busy_b, done_b, err_b, sout_b;

    logic [7:0]  chain_a;
    logic [11:0] chain_b;

    scan_config_loader #(.CHAIN_LENGTH(8), .WORD_WIDTH(8), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .data_in(data_in),
        .data_valid(data_valid), .data_ready(ready_a), .chain_scan_in(sin_a),
        .chain_scan_en(en_a), .chain_scan_out(sout_a), .busy(busy_a),
        .done(done_a), .error(err_a)
    );

    scan_config_loader #(.CHAIN_LENGTH(12), .WORD_WIDTH(8), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .data_in(data_in),
        .data_valid(data_valid), .data_ready(ready_b), .chain_scan_in(sin_b),
        .chain_scan_en(en_b), .chain_scan_out(sout_b), .busy(busy_b),
        .done(done_b), .error(err_b)
    );

    // Chain models: bit shifted in first ends up at the scan_out end.
    assign sout_a = chain_a[7];
    assign sout_b = chain_b[11];

    int flip_req = 0;
    int flip_ack = 0;

    always @(posedge clk) begin
        if (en_a) chain_a <= {chain_a[6:0], sin_a};
    end

    always @(posedge clk) begin : chain_b_model
        logic [11:0] n;
        n = chain_b;
        if (en_b) n = {chain_b[10:0], sin_b};
        if (flip_req != flip_ack) begin
            n[3] = ~n[3];
            flip_ack <= flip_req;
        end
        chain_b <= n;
    end

    // Active-instance view for the monitor.
    logic sel;
    logic m_ready, m_in, m_out, m_en, m_busy, m_done, m_err;
    assign m_ready = sel ? ready_b : ready_a;
    assign m_in    = sel ? sin_b   : sin_a;
    assign m_out   = sel ? sout_b  : sout_a;
    assign m_en    = sel ? en_b    : en_a;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_done  = sel ? done_b  : done_a;
    assign m_err   = sel ? err_b   : err_a;

    bit          bit_q[$];
    logic        err_q[$];
    logic [11:0] chain_q[$];

    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    logic inject_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected shift bits while scanning, checks recirculation,
    // and checks error/chain contents whenever done is presented.
    initial begin : monitor
        int shift_seen;
        int verify_seen;
        int len;
        bit b;
        logic [11:0] act_chain;
        shift_seen = 0;
        verify_seen = 0;
        forever begin
            @(negedge clk);
            len = sel ? 12 : 8;
            if (rst) begin
                bit_q.delete();
                err_q.delete();
                chain_q.delete();
                shift_seen = 0;
                verify_seen = 0;
            end else begin
                if (m_en) begin
                    chk("ready_low_while_scanning", m_ready, 0);
                    if (bit_q.size() > 0) begin
                        b = bit_q.pop_front();
                        chk("shift_bit", m_in, b);
                        shift_seen++;
                        if (bit_q.size() == 0 && inject_on) flip_req++;
                    end else begin
                        chk("recirculate", m_in, m_out);
                        verify_seen++;
                    end
                end
                if (m_done) begin
                    done_cnt++;
                    chk("shift_cycles", shift_seen, len);
                    chk("verify_cycles", verify_seen, len);
                    act_chain = sel ? chain_b : {4'b0, chain_a};
                    if (err_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        chk("error_flag", m_err, err_q.pop_front());
                        chk("chain_contents", act_chain, chain_q.pop_front());
                    end
                    shift_seen = 0;
                    verify_seen = 0;
                end
            end
        end
    end

    task automatic begin_load(input logic [11:0] exp_chain, input logic exp_err);
        chain_q.push_back(exp_chain);
        err_q.push_back(exp_err);
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int n);
        int t;
        t = 0;
        data_in = w;
        data_valid = 1'b1;
        for (int i = 0; i < n; i++) bit_q.push_back(w[i]);
        while (!m_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", m_ready, 1);
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!m_done && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("done_wait", m_done, 1);
    endtask

    initial begin : stimulus
        int d0;
        int t;
        logic [11:0] snap;
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        data_valid = 1'b0;
        data_in = 8'h00;
        sel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready_a, 0);
        chk("rst_scan_in", sin_a, 0);
        chk("rst_scan_en", en_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_error", err_a, 0);
        chk("rst_busy_b", busy_b, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: L=8, single word 0xA5.
        sel = 1'b0;
        d0 = done_cnt;
        begin_load(12'h0A5, 1'b0);
        chk("t1_busy", m_busy, 1);
        send_word(8'hA5, 8);
        wait_done();
        @(negedge clk);
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_done_low", m_done, 0);
        chk("t1_idle", m_busy, 0);

        // 2: L=12, words 0x3C then low nibble of 0x05.
        sel = 1'b1;
        begin_load(12'h3CA, 1'b0);
        send_word(8'h3C, 8);
        send_word(8'h05, 4);
        wait_done();
        @(negedge clk);

        // 3: host stalls for 5 cycles between words.
        begin_load(12'h817, 1'b0);
        send_word(8'h81, 8);
        t = 0;
        while (!m_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("t3_ready", m_ready, 1);
        snap = chain_b;
        repeat (5) begin
            chk("t3_scan_en_low", m_en, 0);
            chk("t3_chain_static", chain_b, snap);
            @(negedge clk);
        end
        send_word(8'h0E, 4);
        wait_done();
        @(negedge clk);

        // 4: corrupt one chain bit before VERIFY.
        inject_on = 1'b1;
        begin_load(12'h5A4, 1'b1);
        send_word(8'h5A, 8);
        send_word(8'h03, 4);
        wait_done();
        @(negedge clk);
        inject_on = 1'b0;
        chk("t4_error_sticky", m_err, 1);
        begin_load(12'h000, 1'b0);
        chk("t4_error_cleared", m_err, 0);
        send_word(8'h00, 8);
        send_word(8'h00, 4);
        wait_done();
        @(negedge clk);

        // 5: async reset during the third SHIFT bit.
        sel = 1'b0;
        begin_load(12'h000, 1'b0);
        send_word(8'h96, 8);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_ready", ready_a, 0);
        chk("t5_scan_in", sin_a, 0);
        chk("t5_scan_en", en_a, 0);
        chk("t5_busy", busy_a, 0);
        chk("t5_done", done_a, 0);
        chk("t5_error", err_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        begin_load(12'h0FF, 1'b0);
        send_word(8'hFF, 8);
        wait_done();
        @(negedge clk);

        // 6: start pulses in LOAD, SHIFT and FINISH are ignored.
        sel = 1'b1;
        d0 = done_cnt;
        begin_load(12'h48F, 1'b0);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("t6_still_load", m_ready, 1);
        send_word(8'h12, 8);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        send_word(8'h0F, 4);
        wait_done();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (4) begin
            chk("t6_no_restart", m_busy, 0);
            @(negedge clk);
        end
        chk("t6_single_done", done_cnt - d0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
